// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low matrix keypad and reports debounced presses as key_valid pulses with key_code.
// Latency: press stable from reset release -> key_valid in the cycle after frame edge 4 (160 cycles at defaults).
// Backpressure: none; key_valid is a single-cycle pulse and key_code holds until the next accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 10,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_10000Hz,
  input  logic       reset,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;
  typedef enum logic {IDLE, PRESSED} state_t;

  logic [1:0]    col_s1_unused_guard;
  logic [3:0]    col_s1, col_s2;
  logic [DW-1:0] div_cnt;
  logic [1:0]    row_idx;
  logic [11:0]   acc_low;
  logic [15:0]   frame_low;
  logic [4:0]    ones;
  logic [3:0]    low_idx;
  res_t          frame_res, prev_res;
  logic [3:0]    frame_code, prev_code;
  logic [3:0]    db_cnt, cnt_nxt;
  logic          div_last, frame_edge, hit;
  state_t        state, state_nxt;
  logic          pulse;

  assign col_s1_unused_guard = 2'b00;
  assign div_last   = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_edge = div_last && (row_idx == 2'd3);
  assign key_row    = ~(4'b0001 << row_idx);
  assign key_held   = (state == PRESSED);

  // Two-flop synchroniser on the column lines; idle (pulled-up) value is all ones.
  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      col_s1 <= 4'b1111;
      col_s2 <= 4'b1111;
    end else begin
      col_s1 <= key_col;
      col_s2 <= col_s1;
    end
  end

  // Row dwell counter and row index; the row advances on the same edge its columns are sampled.
  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      row_idx <= 2'd0;
    end else if (div_last) begin
      div_cnt <= '0;
      row_idx <= row_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Accumulate low columns for rows 0..2; row 3 is taken straight from the synchroniser at frame end.
  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      acc_low <= '0;
    end else if (div_last && (row_idx != 2'd3)) begin
      acc_low[row_idx*4 +: 4] <= ~col_s2;
    end
  end

  // Classify the whole frame: count low positions and locate the key when exactly one is low.
  always_comb begin
    frame_low  = {~col_s2, acc_low};
    ones       = 5'd0;
    low_idx    = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_low[i]) begin
        ones    = ones + 5'd1;
        low_idx = 4'(i);
      end
    end
    frame_res  = RES_NONE;
    frame_code = 4'd0;
    if (ones == 5'd1) begin
      frame_res  = RES_SINGLE;
      frame_code = low_idx;
    end else if (ones != 5'd0) begin
      frame_res  = RES_MULTI;
    end
    if ((frame_res == prev_res) && (frame_code == prev_code))
      cnt_nxt = (db_cnt == 4'd15) ? 4'd15 : db_cnt + 4'd1;
    else
      cnt_nxt = 4'd1;
    hit = (cnt_nxt == 4'(DEBOUNCE_SCANS));
  end

  // Debounce history: consecutive identical frame results, saturating at 15.
  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      prev_res  <= RES_NONE;
      prev_code <= 4'd0;
      db_cnt    <= 4'd0;
    end else if (frame_edge) begin
      prev_res  <= frame_res;
      prev_code <= frame_code;
      db_cnt    <= cnt_nxt;
    end
  end

  // Press/release state register plus the registered pulse and code it produces.
  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      state     <= state_nxt;
      key_valid <= pulse;
      if (pulse) key_code <= frame_code;
    end
  end

  // Accept a debounced single key while idle; leave only on a debounced all-released frame.
  always_comb begin
    state_nxt = state;
    pulse     = 1'b0;
    if (frame_edge) begin
      case (state)
        IDLE: begin
          if ((frame_res == RES_SINGLE) && hit) begin
            state_nxt = PRESSED;
            pulse     = 1'b1;
          end
        end
        PRESSED: begin
          if ((frame_res == RES_NONE) && hit) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: board model drives the columns from a pressed-key map.
// A frame-level reference model predicts key_row, key_valid, key_code and key_held every cycle.
// Directed scenarios (reset walk, press, bounce, chords, reset abort, short press) then random presses.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int DEB = 4;

  logic        clk_10000Hz = 1'b0;
  logic        reset;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] pressed;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          m_n;
  logic [15:0] m_seen;
  int          m_res;
  int          m_cnt;
  logic [3:0]  m_code;
  logic        m_held;
  logic [3:0]  exp_code;
  logic        exp_valid;
  logic [15:0] p0 = '0, p1 = '0, p2 = '0;
  int          pulses = 0;
  int          last_pulse_n = -1;

  always #5 clk_10000Hz = ~clk_10000Hz;

  // keypad matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    key_col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_row[r] && pressed[r*4+c]) key_col[c] = 1'b0;
  end

  keypad_scanner #(.SCAN_DIV(10), .DEBOUNCE_SCANS(DEB)) dut (
    .clk_10000Hz(clk_10000Hz),
    .reset      (reset),
    .key_col    (key_col),
    .key_row    (key_row),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_held   (key_held)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_seen = '0; m_res = 0; m_cnt = 0; m_code = 4'd0;
    m_held = 1'b0; exp_code = 4'd0; exp_valid = 1'b0;
  endtask

  // one active clock edge: rows sampled every 10 edges, frame judged after row 3
  task automatic model_step();
    int r, ones, res;
    logic [3:0] code;
    m_n++;
    exp_valid = 1'b0;
    if (m_n % 10 == 0) begin
      r = ((m_n / 10) - 1) % 4;
      for (int c = 0; c < 4; c++) m_seen[r*4+c] = p2[r*4+c];
      if (r == 3) begin
        ones = $countones(m_seen);
        res  = (ones == 0) ? 0 : (ones == 1) ? 1 : 2;
        code = 4'd0;
        if (res == 1)
          for (int i = 0; i < 16; i++) if (m_seen[i]) code = 4'(i);
        if (res == m_res && code == m_code) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        else begin m_cnt = 1; m_res = res; m_code = code; end
        if (!m_held && res == 1 && m_cnt == DEB) begin
          m_held = 1'b1; exp_valid = 1'b1; exp_code = code;
        end else if (m_held && res == 0 && m_cnt == DEB) begin
          m_held = 1'b0;
        end
      end
    end
  endtask

  // per-cycle monitor, sampling on the falling edge
  initial begin
    logic rst_e;
    logic [3:0] row_exp;
    forever begin
      @(posedge clk_10000Hz);
      rst_e = reset;
      @(negedge clk_10000Hz);
      p2 = p1; p1 = p0; p0 = pressed;
      if (reset || rst_e) model_reset();
      else model_step();
      row_exp = ~(4'b0001 << ((m_n / 10) % 4));
      chk("key_row",   key_row,   row_exp);
      chk("key_valid", key_valid, exp_valid);
      chk("key_code",  key_code,  exp_code);
      chk("key_held",  key_held,  m_held);
      if (key_valid === 1'b1) begin
        pulses++;
        last_pulse_n = m_n;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_10000Hz);
    #1;
  endtask

  initial begin
    int base, k, sel;
    logic got;
    reset = 1'b1;
    pressed = '0;
    cyc(3);
    reset = 1'b0;

    // no keys: rows walk, no pulses
    base = pulses;
    cyc(200);
    chk("t1_pulses", pulses - base, 0);
    chk("t1_held", key_held, 0);

    // key row2 col1 held from reset release
    reset = 1'b1;
    cyc(2);
    pressed = 16'h0200;
    reset = 1'b0;
    base = pulses;
    cyc(170);
    chk("t2_pulses", pulses - base, 1);
    chk("t2_edge", last_pulse_n, 160);
    chk("t2_code", key_code, 9);
    chk("t2_held", key_held, 1);
    pressed = '0;
    cyc(250);
    chk("t2_release", key_held, 0);

    // key 3 bouncing, then stable
    cyc($urandom_range(0, 39));
    base = pulses;
    for (int i = 0; i < 100; i++) begin
      if (i % 7 == 0) pressed[3] = ~pressed[3];
      cyc(1);
    end
    chk("t3_bounce", pulses - base, 0);
    pressed = 16'h0008;
    base = pulses;
    cyc(200);
    chk("t3_pulses", pulses - base, 1);
    chk("t3_code", key_code, 3);
    pressed = '0;
    cyc(250);

    // hold 5, chord with 10, drop 10, release, then press 10
    base = pulses;
    pressed = 16'h0020;
    cyc(220);
    pressed = 16'h0420;
    cyc(120);
    pressed = 16'h0020;
    cyc(200);
    chk("t4_one_pulse", pulses - base, 1);
    chk("t4_code5", key_code, 5);
    chk("t4_held", key_held, 1);
    pressed = '0;
    cyc(220);
    chk("t4_release", key_held, 0);
    pressed = 16'h0400;
    cyc(220);
    chk("t4_second", pulses - base, 2);
    chk("t4_code10", key_code, 10);
    pressed = '0;
    cyc(250);

    // reset while a key is held
    k = $urandom_range(0, 15);
    pressed = 16'(1 << k);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      cyc(1);
      if (key_valid) got = 1'b1;
    end
    chk("t5_pulse_seen", got, 1);
    cyc(50);
    reset = 1'b1;
    #1;
    chk("t5_rst_row", key_row, 4'b1110);
    chk("t5_rst_valid", key_valid, 0);
    chk("t5_rst_code", key_code, 0);
    chk("t5_rst_held", key_held, 0);
    cyc(3);
    reset = 1'b0;
    base = pulses;
    cyc(230);
    chk("t5_pulses", pulses - base, 1);
    chk("t5_edge", last_pulse_n, 160);
    chk("t5_code", key_code, k);

    // press shorter than the debounce window
    pressed = '0;
    cyc(250);
    base = pulses;
    pressed = 16'(1 << $urandom_range(0, 15));
    cyc(120);
    pressed = '0;
    cyc(250);
    chk("t6_pulses", pulses - base, 0);
    chk("t6_held", key_held, 0);

    // random singles, chords and short taps
    repeat (20) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: pressed = '0;
        1: pressed = 16'(1 << $urandom_range(0, 15));
        2: pressed = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
        default: pressed = 16'(1 << $urandom_range(0, 15));
      endcase
      cyc((sel == 3) ? $urandom_range(20, 130) : $urandom_range(60, 300));
    end
    pressed = '0;
    cyc(250);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
